// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection, transmitter FSM states and the
// frame-length helper used to size the bit counter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Serial bits in one frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with asynchronous active-low reset.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   push_i, data_i        write request and word (ignored while full)
//   pop_i,  data_o        read request (ignored while empty), head word
//   full_o, empty_o       status flags
//   count_o               words currently held
module uart_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(depth):0]   count_o
);

  localparam int unsigned AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, configurable frame and clear-to-send.
// Ports:
//   _clock, _reset_n   clock, async active-low reset
//   _in, _in_valid     word to send and its strobe
//   _in_ready          FIFO not full
//   _cts               permits a new frame (sampled in IDLE / end of stop)
//   _out               registered serial line, idle high, LSB first
//   _busy              frame in progress or FIFO non-empty
//   _fifo_count        words held in the FIFO
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned clocks_per_bit = 4,
  parameter int unsigned data_bits      = 8,
  parameter int unsigned parity_mode    = 0,
  parameter int unsigned stop_bits      = 1,
  parameter int unsigned fifo_depth     = 4
) (
  input  logic                          _clock,
  input  logic                          _reset_n,
  input  logic [data_bits-1:0]          _in,
  input  logic                          _in_valid,
  output logic                          _in_ready,
  input  logic                          _cts,
  output logic                          _out,
  output logic                          _busy,
  output logic [$clog2(fifo_depth):0]   _fifo_count
);

  if (clocks_per_bit < 2 || clocks_per_bit > 65535) begin : g_bad_cpb
    $error("uart_tx_fifo: clocks_per_bit out of range");
  end
  if (data_bits < 5 || data_bits > 9) begin : g_bad_db
    $error("uart_tx_fifo: data_bits out of range");
  end
  if (parity_mode > 2) begin : g_bad_par
    $error("uart_tx_fifo: parity_mode must be 0, 1 or 2");
  end
  if (stop_bits < 1 || stop_bits > 2) begin : g_bad_stop
    $error("uart_tx_fifo: stop_bits must be 1 or 2");
  end
  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: fifo_depth must be a power of two >= 2");
  end

  localparam int unsigned FB            = frame_bits(data_bits, parity_mode, stop_bits);
  localparam parity_t     PMODE         = parity_t'(parity_mode[1:0]);
  localparam logic [15:0] DLY_LAST      = 16'(clocks_per_bit - 1);
  localparam logic [3:0]  BIT_LAST_DATA = 4'(data_bits);
  localparam logic [3:0]  BIT_LAST      = 4'(FB - 1);

  tx_state_t            state_q, state_d;
  logic [15:0]          dly_q, dly_d;
  logic [3:0]           bit_q, bit_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 out_q, out_d;

  logic                 pop, load, boundary, can_load, fifo_full, fifo_empty, par_bit;
  logic [data_bits-1:0] fifo_data;

  uart_fifo #(
    .width(data_bits),
    .depth(fifo_depth)
  ) u_fifo (
    .clk_i  (_clock),
    .rst_ni (_reset_n),
    .push_i (_in_valid),
    .data_i (_in),
    .pop_i  (pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(_fifo_count)
  );

  assign _in_ready = ~fifo_full;
  assign _out      = out_q;
  assign _busy     = (state_q != IDLE) | ~fifo_empty;
  assign boundary  = (dly_q == DLY_LAST);
  assign can_load  = ~fifo_empty & _cts;
  // Accumulator holds XOR of the bits already sent; fold in the last one.
  assign par_bit   = (PMODE == PAR_ODD) ? ~(par_q ^ shift_q[0]) : (par_q ^ shift_q[0]);

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    out_d   = out_q;
    load    = 1'b0;
    pop     = 1'b0;

    if (state_q != IDLE) begin
      dly_d = boundary ? '0 : dly_q + 16'd1;
      if (boundary) bit_d = bit_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (can_load) load = 1'b1;
      end
      START: begin
        if (boundary) begin
          state_d = DATA;
          out_d   = shift_q[0];
        end
      end
      DATA: begin
        if (boundary) begin
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          if (bit_q == BIT_LAST_DATA) begin
            if (PMODE != PAR_NONE) begin
              state_d = PARITY;
              out_d   = par_bit;
            end else begin
              state_d = STOP;
              out_d   = 1'b1;
            end
          end else begin
            out_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (boundary) begin
          state_d = STOP;
          out_d   = 1'b1;
        end
      end
      STOP: begin
        if (boundary && bit_q == BIT_LAST) begin
          if (can_load) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            bit_d   = '0;
            out_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 1'b1;
      end
    endcase

    // Shared by IDLE and end-of-stop so back-to-back frames have no gap.
    if (load) begin
      pop     = 1'b1;
      shift_d = fifo_data;
      par_d   = 1'b0;
      bit_d   = '0;
      dly_d   = '0;
      state_d = START;
      out_d   = 1'b0;
    end
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= IDLE;
      dly_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8E1/cpb4, 7O2/cpb4, 8N1/cpb2).
// Stimulus enqueues expected frames; per-instance monitors decode _out.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] in_a;  logic v_a, rdy_a, cts_a, out_a, busy_a;  logic [2:0] cnt_a;
  logic [6:0] in_b;  logic v_b, rdy_b, cts_b, out_b, busy_b;  logic [2:0] cnt_b;
  logic [7:0] in_c;  logic v_c, rdy_c, cts_c, out_c, busy_c;  logic [2:0] cnt_c;

  uart_tx_fifo #(.clocks_per_bit(4), .data_bits(8), .parity_mode(2), .stop_bits(1), .fifo_depth(4))
    u_a (._clock(clk), ._reset_n(rst_n), ._in(in_a), ._in_valid(v_a), ._in_ready(rdy_a),
         ._cts(cts_a), ._out(out_a), ._busy(busy_a), ._fifo_count(cnt_a));
  uart_tx_fifo #(.clocks_per_bit(4), .data_bits(7), .parity_mode(1), .stop_bits(2), .fifo_depth(4))
    u_b (._clock(clk), ._reset_n(rst_n), ._in(in_b), ._in_valid(v_b), ._in_ready(rdy_b),
         ._cts(cts_b), ._out(out_b), ._busy(busy_b), ._fifo_count(cnt_b));
  uart_tx_fifo #(.clocks_per_bit(2), .data_bits(8), .parity_mode(0), .stop_bits(1), .fifo_depth(4))
    u_c (._clock(clk), ._reset_n(rst_n), ._in(in_c), ._in_valid(v_c), ._in_ready(rdy_c),
         ._cts(cts_c), ._out(out_c), ._busy(busy_c), ._fifo_count(cnt_c));

  // Frame configuration of each instance, written out by hand.
  int cpb_t [3] = '{4, 4, 2};
  int db_t  [3] = '{8, 7, 8};
  int pen_t [3] = '{1, 1, 0};
  int stp_t [3] = '{1, 2, 1};

  // start: -1 any time, -2 immediately after previous frame, >=0 absolute cycle
  typedef struct {
    logic [8:0] data;
    logic       par;
    int         start;
  } exp_t;

  exp_t sb [3][$];
  int   last_end [3] = '{0, 0, 0};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic get_out(input int id);
    case (id)
      0:       return out_a;
      1:       return out_b;
      default: return out_c;
    endcase
  endfunction

  function automatic logic get_busy(input int id);
    case (id)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Serial order: start 0, data LSB first, hand-computed parity, stops (1).
  function automatic logic [15:0] mk_frame(input int id, input logic [8:0] d, input logic p);
    logic [15:0] f;
    int k;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < db_t[id]; i++) f[1+i] = d[i];
    k = 1 + db_t[id];
    if (pen_t[id] != 0) f[k] = p;
    return f;
  endfunction

  task automatic monitor(input int id);
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && get_out(id) === 1'b0) begin
        exp_t e;
        logic [15:0] f, got;
        int nb, cp, st;
        bit have, ok, aborted;
        st = cyc; cp = cpb_t[id];
        nb = 1 + db_t[id] + pen_t[id] + stp_t[id];
        have = (sb[id].size() != 0);
        if (have) e = sb[id].pop_front();
        else begin e.data = '0; e.par = 1'b0; e.start = -1; end
        f = mk_frame(id, e.data, e.par);
        got = '1; ok = 1'b1; aborted = 1'b0;
        for (int k = 0; k < nb * cp; k++) begin
          if (k > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
          if (get_out(id) !== f[k/cp]) ok = 1'b0;
          if (k % cp == 0) got[k/cp] = get_out(id);
        end
        if (!aborted) begin
          total++;
          if (!have) begin
            bad++;
            $display("FAIL frame%0d unexpected: got %04h expected none", id, got);
          end else if (!ok) begin
            bad++;
            $display("FAIL frame%0d data %0h: got %04h expected %04h", id, e.data, got, f);
          end
          if (have && e.start == -2) check($sformatf("gap%0d", id), st, last_end[id]);
          if (have && e.start >= 0)  check($sformatf("latency%0d", id), st, e.start);
          last_end[id] = st + nb * cp;
        end
      end
    end
  endtask

  task automatic push(input int id, input logic [8:0] d, input logic p, input int smode,
                      input bit enq, output int pc);
    exp_t e;
    case (id)
      0:       begin in_a = d[7:0]; v_a = 1'b1; end
      1:       begin in_b = d[6:0]; v_b = 1'b1; end
      default: begin in_c = d[7:0]; v_c = 1'b1; end
    endcase
    @(posedge clk); #1;
    pc = cyc;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    if (enq) begin
      e.data = d; e.par = p;
      e.start = (smode == 1) ? pc + 1 : smode;
      sb[id].push_back(e);
    end
  endtask

  task automatic wait_idle(input int id, input int budget, output int c);
    bit done;
    done = 1'b0;
    c = -1;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (get_busy(id) === 1'b0) begin done = 1'b1; c = cyc; end
    end
    if (!done) check($sformatf("idle timeout%0d", id), 32'd0, 32'd1);
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [8:0] fill_w [5] = '{9'h11, 9'h07, 9'h80, 9'hFF, 9'h5A};
  logic       fill_p [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int pc, pc2, c;
    rst_n = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    cts_a = 1'b0; cts_b = 1'b0; cts_c = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    check("reset out", out_a, 1);
    check("reset ready", rdy_a, 1);
    check("reset busy", busy_a, 0);
    check("reset count", cnt_a, 0);
    check("reset out b/c", {out_b, out_c, rdy_b, rdy_c}, 4'b1111);

    // 8E1, A5: data 1,0,1,0,0,1,0,1, parity 0
    cts_a = 1'b1;
    push(0, 9'h0A5, 1'b0, 1, 1'b1, pc);
    wait_idle(0, 100, c);
    check("8E1 span", c - pc, 45);

    // 7O2: 55 has four ones -> odd parity 1; 54 has three -> 0
    cts_b = 1'b1;
    push(1, 9'h055, 1'b1, 1, 1'b1, pc);
    push(1, 9'h054, 1'b0, -2, 1'b1, pc2);
    wait_idle(1, 200, c);
    check("7O2 span", c - pc, 1 + 2 * 44);

    // 8N1 at two clocks per bit: 20-cycle frame
    cts_c = 1'b1;
    push(2, 9'h03C, 1'b0, 1, 1'b1, pc);
    wait_idle(2, 60, c);
    check("8N1 span", c - pc, 21);

    // FIFO fill with cts low; fifth word must be refused
    cts_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("full ready", rdy_a, 0);
      push(0, fill_w[i], fill_p[i], (i == 0) ? -1 : -2, i < 4, pc);
    end
    check("full count", cnt_a, 4);
    in_a = 8'h5A; v_a = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    v_a = 1'b0;
    check("cts hold out", out_a, 1);
    check("cts hold count", cnt_a, 4);
    check("cts hold busy", busy_a, 1);
    cts_a = 1'b1;
    wait_idle(0, 250, c);
    check("drain count", cnt_a, 0);

    // cts dropped mid-frame: frame finishes, second word waits
    push(0, 9'h03C, 1'b0, 1, 1'b1, pc);
    push(0, 9'h0C1, 1'b1, -1, 1'b1, pc2);
    repeat (9) @(posedge clk);
    #1 cts_a = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("cts drop out", out_a, 1);
    check("cts drop count", cnt_a, 1);
    check("cts drop busy", busy_a, 1);
    cts_a = 1'b1;
    wait_idle(0, 100, c);

    // reset inside the first data bit
    push(0, 9'h096, 1'b0, 1, 1'b1, pc);
    push(0, 9'h069, 1'b0, -1, 1'b1, pc2);
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset count", cnt_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort out", out_a, 1);
    check("abort count", cnt_a, 0);
    check("abort busy", busy_a, 0);
    sb[0].delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("post-reset out", out_a, 1);
    check("post-reset busy", busy_a, 0);

    check("scoreboard drained", sb[0].size() + sb[1].size() + sb[2].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
